// File: rtl/key_conditioner.sv
// Input conditioning for the board buttons and key banks: two-flop synchronisers,
// per-bit debounce, press pulses, one-hot key filtering and octave auto-repeat.
module key_conditioner #(
    parameter int DB_CYCLES    = 2000000,
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 20000000,
    parameter int NKEY         = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      btn_raw,
    input  logic [NKEY-1:0] note_raw,
    input  logic [NKEY-1:0] length_raw,
    output logic            submit,
    output logic            cancle,
    output logic            submit_pulse,
    output logic            cancle_pulse,
    output logic            oct_up_pulse,
    output logic            oct_down_pulse,
    output logic [NKEY-1:0] note_key,
    output logic [NKEY-1:0] length_key,
    output logic            key_conflict
);

    localparam int NB   = 4 + 2 * NKEY;
    localparam int NOTE = 4;
    localparam int LEN  = 4 + NKEY;
    localparam int TMAX = (REPEAT_DELAY > DB_CYCLES) ? REPEAT_DELAY : DB_CYCLES;
    localparam int TW   = $clog2(TMAX);

    localparam logic [TW-1:0] DB_LAST = TW'(DB_CYCLES - 1);
    localparam logic [TW-1:0] RD_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RR_LAST = TW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_e;

    logic [NB-1:0]          sync1_q, sync1_d;
    logic [NB-1:0]          sync2_q, sync2_d;
    logic [NB-1:0]          stable_q, stable_d;
    logic [NB-1:0][TW-1:0]  db_cnt_q, db_cnt_d;
    logic [1:0]             btn_pulse_q, btn_pulse_d;
    logic [NKEY-1:0]        note_key_q, note_key_d;
    logic [NKEY-1:0]        length_key_q, length_key_d;
    logic                   key_conflict_q, key_conflict_d;

    rpt_state_e             rpt_state_q [2];
    rpt_state_e             rpt_state_d [2];
    logic [TW-1:0]          rpt_tmr_q [2];
    logic [TW-1:0]          rpt_tmr_d [2];
    logic [1:0]             oct_pulse_q, oct_pulse_d;
    logic [1:0]             oct_lvl;
    logic                   oct_both;
    logic                   note_multi, length_multi;

    function automatic logic multi_hot(input logic [NKEY-1:0] v);
        return (v & (v - NKEY'(1))) != '0;
    endfunction

    always_comb begin : sync_comb
        sync1_d = {length_raw, note_raw, btn_raw};
        sync2_d = sync1_q;
    end

    always_comb begin : debounce_comb
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < NB; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                stable_d[i] = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + TW'(1);
            end
        end
    end

    // Pulses and octave FSMs look at the level being loaded this edge, so they line up with it.
    always_comb begin : filter_comb
        btn_pulse_d    = stable_d[1:0] & ~stable_q[1:0];
        note_multi     = multi_hot(stable_q[NOTE +: NKEY]);
        length_multi   = multi_hot(stable_q[LEN +: NKEY]);
        note_key_d     = note_multi   ? '0 : stable_q[NOTE +: NKEY];
        length_key_d   = length_multi ? '0 : stable_q[LEN +: NKEY];
        key_conflict_d = note_multi | length_multi;
    end

    always_ff @(posedge clk or posedge rst) begin : datapath_reg
        if (rst) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            stable_q       <= '0;
            db_cnt_q       <= '0;
            btn_pulse_q    <= '0;
            note_key_q     <= '0;
            length_key_q   <= '0;
            key_conflict_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            stable_q       <= stable_d;
            db_cnt_q       <= db_cnt_d;
            btn_pulse_q    <= btn_pulse_d;
            note_key_q     <= note_key_d;
            length_key_q   <= length_key_d;
            key_conflict_q <= key_conflict_d;
        end
    end

    assign oct_lvl  = stable_d[3:2];
    assign oct_both = &oct_lvl;

    always_ff @(posedge clk or posedge rst) begin : rpt_state_reg
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                rpt_state_q[k] <= RPT_IDLE;
                rpt_tmr_q[k]   <= '0;
            end
            oct_pulse_q <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                rpt_state_q[k] <= rpt_state_d[k];
                rpt_tmr_q[k]   <= rpt_tmr_d[k];
            end
            oct_pulse_q <= oct_pulse_d;
        end
    end

    always_comb begin : rpt_next_comb
        for (int k = 0; k < 2; k++) begin
            rpt_state_d[k] = rpt_state_q[k];
            rpt_tmr_d[k]   = '0;
            if (!oct_lvl[k] || oct_both) begin
                rpt_state_d[k] = RPT_IDLE;
            end else begin
                case (rpt_state_q[k])
                    RPT_IDLE: rpt_state_d[k] = RPT_DELAY;
                    RPT_DELAY: begin
                        if (rpt_tmr_q[k] == RD_LAST) rpt_state_d[k] = RPT_REPEAT;
                        else                         rpt_tmr_d[k]   = rpt_tmr_q[k] + TW'(1);
                    end
                    RPT_REPEAT: begin
                        if (rpt_tmr_q[k] != RR_LAST) rpt_tmr_d[k] = rpt_tmr_q[k] + TW'(1);
                    end
                    default: rpt_state_d[k] = RPT_IDLE;
                endcase
            end
        end
    end

    always_comb begin : rpt_out_comb
        oct_pulse_d = '0;
        for (int k = 0; k < 2; k++) begin
            if (oct_lvl[k] && !oct_both) begin
                case (rpt_state_q[k])
                    RPT_IDLE:   oct_pulse_d[k] = 1'b1;
                    RPT_DELAY:  oct_pulse_d[k] = (rpt_tmr_q[k] == RD_LAST);
                    RPT_REPEAT: oct_pulse_d[k] = (rpt_tmr_q[k] == RR_LAST);
                    default:    oct_pulse_d[k] = 1'b0;
                endcase
            end
        end
    end

    assign submit         = stable_q[0];
    assign cancle         = stable_q[1];
    assign submit_pulse   = btn_pulse_q[0];
    assign cancle_pulse   = btn_pulse_q[1];
    assign oct_up_pulse   = oct_pulse_q[0];
    assign oct_down_pulse = oct_pulse_q[1];
    assign note_key       = note_key_q;
    assign length_key     = length_key_q;
    assign key_conflict   = key_conflict_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: a sample-history model of debounce and repeat timing,
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_key_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 5;
    localparam int NK = 7;
    localparam int NB = 4 + 2 * NK;
    localparam int H  = DB + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    btn_raw = 4'hF;
    logic [NK-1:0] note_raw = '1;
    logic [NK-1:0] length_raw = '1;
    logic          submit, cancle, submit_pulse, cancle_pulse;
    logic          oct_up_pulse, oct_down_pulse, key_conflict;
    logic [NK-1:0] note_key, length_key;

    key_conditioner #(
        .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .NKEY(NK)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .note_raw(note_raw),
        .length_raw(length_raw), .submit(submit), .cancle(cancle),
        .submit_pulse(submit_pulse), .cancle_pulse(cancle_pulse),
        .oct_up_pulse(oct_up_pulse), .oct_down_pulse(oct_down_pulse),
        .note_key(note_key), .length_key(length_key), .key_conflict(key_conflict)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: raw samples per edge; a bit takes a new value once the synchronised
    // history shows DB consecutive samples of it. Repeat pulses come from elapsed
    // cycles since an octave button became the sole held one.
    logic [NB-1:0] hist [H];
    logic [NB-1:0] stab = '0;
    logic [NB-1:0] prev = '0;
    logic [1:0]    act_prev = '0;
    logic [1:0]    exp_oct = '0;
    int            elapsed [2];
    bit            same_m;
    bit            act_m;

    function automatic logic [NK-1:0] filt(input logic [NK-1:0] v);
        return ($countones(v) == 1) ? v : '0;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            for (int k = 0; k < H; k++) hist[k] = '0;
            stab = '0;
            prev = '0;
            act_prev = '0;
            exp_oct = '0;
            elapsed[0] = 0;
            elapsed[1] = 0;
        end else begin
            for (int k = H - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = {length_raw, note_raw, btn_raw};
            prev = stab;
            for (int b = 0; b < NB; b++) begin
                same_m = 1'b1;
                for (int j = 2; j <= DB + 1; j++)
                    if (hist[j][b] !== hist[2][b]) same_m = 1'b0;
                if (same_m) stab[b] = hist[2][b];
            end
            for (int k = 0; k < 2; k++) begin
                act_m = stab[2+k] && !(stab[2] && stab[3]);
                if (!act_m) begin
                    exp_oct[k] = 1'b0;
                end else begin
                    elapsed[k] = act_prev[k] ? elapsed[k] + 1 : 0;
                    exp_oct[k] = (elapsed[k] == 0) || (elapsed[k] == RD) ||
                                 (elapsed[k] > RD && (elapsed[k] - RD) % RR == 0);
                end
                act_prev[k] = act_m;
            end
        end
    end

    int up_log[$];
    int dn_log[$];

    always @(posedge clk) begin
        #1;
        check("submit", 32'(submit), 32'(stab[0]));
        check("cancle", 32'(cancle), 32'(stab[1]));
        check("submit_pulse", 32'(submit_pulse), 32'(stab[0] & ~prev[0]));
        check("cancle_pulse", 32'(cancle_pulse), 32'(stab[1] & ~prev[1]));
        check("note_key", 32'(note_key), 32'(filt(prev[4 +: NK])));
        check("length_key", 32'(length_key), 32'(filt(prev[4+NK +: NK])));
        check("key_conflict", 32'(key_conflict),
              32'(($countones(prev[4 +: NK]) > 1) || ($countones(prev[4+NK +: NK]) > 1)));
        check("oct_up_pulse", 32'(oct_up_pulse), 32'(exp_oct[0]));
        check("oct_down_pulse", 32'(oct_down_pulse), 32'(exp_oct[1]));
        if (oct_up_pulse === 1'b1) up_log.push_back(cyc);
        if (oct_down_pulse === 1'b1) dn_log.push_back(cyc);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int c0, c1, c2, c3;
    int off4 [7] = '{0, 10, 15, 20, 25, 30, 35};

    initial begin
        // 1. reset with every raw input high
        tick(3);
        check("t1_rst_submit", 32'(submit), 0);
        check("t1_rst_pulses", 32'({submit_pulse, cancle_pulse, oct_up_pulse, oct_down_pulse}), 0);
        check("t1_rst_keys", 32'({note_key, length_key, key_conflict}), 0);
        rst = 1'b0;
        tick(5);
        check("t1_submit_edge5", 32'(submit), 0);
        tick(1);
        check("t1_submit_edge6", 32'(submit), 1);
        check("t1_submit_pulse6", 32'(submit_pulse), 1);
        check("t1_cancle_pulse6", 32'(cancle_pulse), 1);
        tick(1);
        check("t1_submit_pulse7", 32'(submit_pulse), 0);
        check("t1_conflict7", 32'(key_conflict), 1);
        rst = 1'b1;
        btn_raw = '0; note_raw = '0; length_raw = '0;
        tick(2);
        rst = 1'b0;
        tick(2);

        // 2. glitch rejection
        btn_raw[0] = 1'b1;
        tick(3);
        btn_raw[0] = 1'b0;
        tick(10);
        check("t2_glitch", 32'(submit), 0);
        btn_raw[0] = 1'b1;
        tick(5);
        check("t2_edge5", 32'(submit), 0);
        tick(1);
        check("t2_edge6", 32'(submit), 1);
        check("t2_pulse6", 32'(submit_pulse), 1);
        btn_raw[0] = 1'b0;
        tick(10);
        check("t2_release", 32'(submit), 0);

        // 3. one-hot filter
        note_raw = 7'b0000100;
        tick(6);
        check("t3_edge6", 32'(note_key), 0);
        tick(1);
        check("t3_edge7", 32'(note_key), 32'b0000100);
        note_raw = 7'b0000101;
        tick(6);
        check("t3_two_edge6", 32'(note_key), 32'b0000100);
        tick(1);
        check("t3_two_key", 32'(note_key), 0);
        check("t3_two_conflict", 32'(key_conflict), 1);
        note_raw = 7'b0000001;
        tick(7);
        check("t3_back_key", 32'(note_key), 32'b0000001);
        check("t3_back_conflict", 32'(key_conflict), 0);
        note_raw = '0;
        length_raw = 7'b1000000;
        tick(7);
        check("t3_length", 32'(length_key), 32'b1000000);
        length_raw = '0;
        tick(8);

        // 4. auto-repeat
        up_log.delete();
        c0 = cyc;
        btn_raw[2] = 1'b1;
        tick(40);
        btn_raw[2] = 1'b0;
        tick(15);
        check("t4_count", 32'(up_log.size()), 7);
        for (int i = 0; i < up_log.size() && i < 7; i++)
            check($sformatf("t4_pulse%0d", i), 32'(up_log[i] - c0), 32'(6 + off4[i]));

        // 5. both octave buttons held
        up_log.delete();
        dn_log.delete();
        c0 = cyc;
        btn_raw[2] = 1'b1;
        tick(10);
        c1 = cyc;
        btn_raw[3] = 1'b1;
        tick(20);
        check("t5_both_quiet", 32'({oct_up_pulse, oct_down_pulse}), 0);
        c2 = cyc;
        btn_raw[2] = 1'b0;
        tick(14);
        btn_raw[3] = 1'b0;
        tick(10);
        check("t5_up_count", 32'(up_log.size()), 1);
        if (up_log.size() > 0) check("t5_up_first", 32'(up_log[0] - c0), 6);
        check("t5_dn_count", 32'(dn_log.size()), 2);
        if (dn_log.size() > 1) begin
            check("t5_dn_fresh", 32'(dn_log[0] - c2), 6);
            check("t5_dn_delay", 32'(dn_log[1] - c2), 16);
        end
        check("t5_c1", 32'(c1 - c0), 10);

        // 6. reset during repeat
        up_log.delete();
        c0 = cyc;
        btn_raw[2] = 1'b1;
        tick(26);
        check("t6_pulse_before_rst", 32'(oct_up_pulse), 1);
        rst = 1'b1;
        #1;
        check("t6_pulse_async_clear", 32'(oct_up_pulse), 0);
        tick(3);
        rst = 1'b0;
        c3 = cyc;
        tick(15);
        btn_raw[2] = 1'b0;
        tick(10);
        check("t6_count", 32'(up_log.size()), 6);
        if (up_log.size() == 6) begin
            check("t6_pre3", 32'(up_log[3] - c0), 26);
            check("t6_post0", 32'(up_log[4] - c3), 6);
            check("t6_post1", 32'(up_log[5] - c3), 16);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
